// File: rtl/suprloco_mem_pkg.sv
// Shared definitions for the SuprLoco memory blocks: clear-sequencer state
// encoding, the default byte-lane width and the lane-count helper.
package suprloco_mem_pkg;

    localparam int LW_DEF = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    // Number of byte lanes in a DW-bit word made of LW-bit lanes.
    function automatic int calc_nl(input int dw, input int lw);
        return dw / lw;
    endfunction

endpackage

// File: rtl/suprloco_dpram_clr.sv
// Clear sequencer for suprloco_dpram. After reset it walks the counter from
// address 0 to 2**AW-1, strobing one write per cycle, then parks in READY
// until the next reset. The counter carries one extra bit that marks the end
// of the sweep, so it never wraps into a second pass.
module suprloco_dpram_clr
    import suprloco_mem_pkg::*;
#(
    parameter int AW = 10
)(
    input  logic          i_MCLK,
    input  logic          i_RST_n,
    output logic [AW-1:0] o_ADDR,
    output logic          o_WE,
    output logic          o_READY,
    output clr_state_t    o_STATE
);

    clr_state_t  state;
    clr_state_t  state_nxt;
    logic [AW:0] cnt;

    // State register; reset always restarts the sweep.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and strobes: write while addresses remain, then leave CLEAR
    // on the edge after the last address was written.
    always_comb begin
        state_nxt = state;
        o_WE      = 1'b0;
        o_READY   = 1'b0;
        case (state)
            ST_CLEAR: begin
                o_WE = !cnt[AW];
                if (cnt[AW]) begin
                    state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                o_READY = 1'b1;
            end
            default: begin
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Sweep address counter; advances only on cycles that actually write.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            cnt <= '0;
        end else if (o_WE) begin
            cnt <= cnt + {{AW{1'b0}}, 1'b1};
        end
    end

    assign o_ADDR  = cnt[AW-1:0];
    assign o_STATE = state;

endmodule

// File: rtl/suprloco_dpram.sv
// suprloco_dpram: true dual-port synchronous RAM shared by the CPU and video
// sides of the SuprLoco core. Both ports read/write on i_MCLK with byte-lane
// enables; on a same-address double write port A owns every lane it enables.
// A read that collides with the other port's write returns the old word.
//
// Build option SUPRLOCO_DPRAM_CLEAR_EN: when defined, a clear sequencer fills
// the array with CLR_VAL after reset and holds off external accesses until
// o_READY. When undefined, o_READY simply follows i_RST_n and the contents are
// whatever image (simhexfile) the memory-initialisation flow preloads.
//
// Port handshake: accesses have no backpressure; a strobe sampled on a rising
// edge while the array is accepting is performed on that edge, and read data
// appears on DOUT after that same edge. WR takes precedence over RD, and DOUT
// only changes on an accepted read.
module suprloco_dpram
    import suprloco_mem_pkg::*;
#(
    parameter int             AW         = 10,
    parameter int             DW         = 8,
    parameter int             LW         = LW_DEF,
    parameter logic [DW-1:0]  CLR_VAL    = '0,
    parameter string          simhexfile = ""
)(
    input  logic                          i_MCLK,
    input  logic                          i_RST_n,
    input  logic [AW-1:0]                 i_A_ADDR,
    input  logic [DW-1:0]                 i_A_DIN,
    input  logic [calc_nl(DW, LW)-1:0]    i_A_BE,
    input  logic                          i_A_RD,
    input  logic                          i_A_WR,
    output logic [DW-1:0]                 o_A_DOUT,
    input  logic [AW-1:0]                 i_B_ADDR,
    input  logic [DW-1:0]                 i_B_DIN,
    input  logic [calc_nl(DW, LW)-1:0]    i_B_BE,
    input  logic                          i_B_RD,
    input  logic                          i_B_WR,
    output logic [DW-1:0]                 o_B_DOUT,
    output logic                          o_READY
);

    localparam int NL    = calc_nl(DW, LW);
    localparam int DEPTH = 1 << AW;

    reg   [DW-1:0] mem [0:DEPTH-1];

    logic          ext_en;
    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          a_we;
    logic          a_rd;
    logic          b_we;
    logic          b_rd;
    logic          same_addr;

`ifdef SUPRLOCO_DPRAM_CLEAR_EN
    clr_state_t    clr_state;

    suprloco_dpram_clr #(
        .AW(AW)
    ) u_clr (
        .i_MCLK  (i_MCLK),
        .i_RST_n (i_RST_n),
        .o_ADDR  (clr_addr),
        .o_WE    (clr_we),
        .o_READY (o_READY),
        .o_STATE (clr_state)
    );

    // External ports are locked out for as long as the sweep is writing.
    assign ext_en = (clr_state == ST_READY) || !clr_we;
`else
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
    assign ext_en   = 1'b1;
    assign o_READY  = i_RST_n;
`endif

    assign a_we      = ext_en && i_A_WR;
    assign a_rd      = ext_en && !i_A_WR && i_A_RD;
    assign b_we      = ext_en && i_B_WR;
    assign b_rd      = ext_en && !i_B_WR && i_B_RD;
    assign same_addr = (i_A_ADDR == i_B_ADDR);

    // Port A write side; the clear sweep takes this write path first.
    always @(posedge i_MCLK) begin
        if (clr_we) begin
            mem[clr_addr] <= CLR_VAL;
        end else if (a_we) begin
            for (int n = 0; n < NL; n++) begin
                if (i_A_BE[n]) begin
                    mem[i_A_ADDR][n*LW +: LW] <= i_A_DIN[n*LW +: LW];
                end
            end
        end
    end

    // Port B write side; lanes port A writes at the same address are left to A.
    always @(posedge i_MCLK) begin
        if (b_we) begin
            for (int n = 0; n < NL; n++) begin
                if (i_B_BE[n] && !(a_we && same_addr && i_A_BE[n])) begin
                    mem[i_B_ADDR][n*LW +: LW] <= i_B_DIN[n*LW +: LW];
                end
            end
        end
    end

    // Port A registered read; returns the pre-write word on a collision.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_A_DOUT <= '0;
        end else if (a_rd) begin
            o_A_DOUT <= mem[i_A_ADDR];
        end
    end

    // Port B registered read; returns the pre-write word on a collision.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            o_B_DOUT <= '0;
        end else if (b_rd) begin
            o_B_DOUT <= mem[i_B_ADDR];
        end
    end

endmodule

// File: tb/tb_suprloco_dpram.sv
// Bench for suprloco_dpram (AW=4, DW=16, LW=8, CLR_VAL=16'hA5A5). Works with
// SUPRLOCO_DPRAM_CLEAR_EN defined or not; expectations follow the build.
module tb_suprloco_dpram;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam logic [15:0] CLR = 16'hA5A5;
`ifdef SUPRLOCO_DPRAM_CLEAR_EN
  localparam bit CLEAR_BUILD = 1'b1;
`else
  localparam bit CLEAR_BUILD = 1'b0;
`endif
  localparam int EXP_READY_N = CLEAR_BUILD ? DEPTH + 1 : 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_din = '0, b_din = '0;
  logic [1:0]    a_be = '0, b_be = '0;
  logic          a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
  logic [DW-1:0] a_dout, b_dout;
  logic          ready;

  suprloco_dpram #(
    .AW(AW), .DW(DW), .LW(8), .CLR_VAL(CLR), .simhexfile("")
  ) dut (
    .i_MCLK(clk), .i_RST_n(rst_n),
    .i_A_ADDR(a_addr), .i_A_DIN(a_din), .i_A_BE(a_be), .i_A_RD(a_rd), .i_A_WR(a_wr), .o_A_DOUT(a_dout),
    .i_B_ADDR(b_addr), .i_B_DIN(b_din), .i_B_BE(b_be), .i_B_RD(b_rd), .i_B_WR(b_wr), .o_B_DOUT(b_dout),
    .o_READY(ready)
  );

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural model ----------------
  // Memory as an array plus a "fully known" flag per word; edges counts
  // rising edges since reset release.
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [15:0] m_a, m_b;
  bit          m_a_ok, m_b_ok;
  int          m_edges = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
  end

  task automatic m_write(input logic [3:0] ad, input logic [15:0] d, input logic [1:0] be);
    for (int n = 0; n < 2; n++) if (be[n]) m_mem[ad][n*8 +: 8] = d[n*8 +: 8];
    if (be == 2'b11) m_known[ad] = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = '0; m_b = '0; m_a_ok = 1'b1; m_b_ok = 1'b1; m_edges = 0;
    end else begin
      m_edges++;
      if (CLEAR_BUILD && m_edges <= DEPTH) begin
        m_mem[m_edges-1] = CLR;
        m_known[m_edges-1] = 1'b1;
      end else begin
        // reads see the contents from before this edge's writes
        if (!a_wr && a_rd) begin m_a = m_mem[a_addr]; m_a_ok = m_known[a_addr]; end
        if (!b_wr && b_rd) begin m_b = m_mem[b_addr]; m_b_ok = m_known[b_addr]; end
        // B first, then A on top: A owns every lane it enables
        if (b_wr) m_write(b_addr, b_din, b_be);
        if (a_wr) m_write(a_addr, a_din, a_be);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic exp_ready;
    exp_ready = rst_n && (!CLEAR_BUILD || m_edges > DEPTH);
    tests++;
    if (ready !== exp_ready) begin
      fails++;
      $display("FAIL ready_cyc t=%0t actual=%0b required=%0b", $time, ready, exp_ready);
    end
    if (m_a_ok) begin
      tests++;
      if (a_dout !== m_a) begin
        fails++;
        $display("FAIL a_dout_cyc t=%0t actual=%h required=%h", $time, a_dout, m_a);
      end
    end
    if (m_b_ok) begin
      tests++;
      if (b_dout !== m_b) begin
        fails++;
        $display("FAIL b_dout_cyc t=%0t actual=%h required=%h", $time, b_dout, m_b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0; a_be = 2'b00; b_be = 2'b00;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      cyc();
      n++;
      if (n == 10) b_wr = 0;
    end
    check(name, 16'(n), 16'(EXP_READY_N));
  endtask

  // ---------------- directed stimulus ----------------
  typedef struct { logic [3:0] ad; logic [15:0] d; } vec_t;
  vec_t vecs [3];

  initial begin
    vecs[0] = '{4'd0,  16'hC0DE};
    vecs[1] = '{4'd15, 16'h7E57};
    vecs[2] = '{4'd8,  16'h5A3C};

    idle();
    repeat (3) cyc();
    check("rst_a_dout", a_dout, 16'h0000);
    check("rst_b_dout", b_dout, 16'h0000);
    check("rst_ready", {15'd0, ready}, 16'h0000);

    // clear sweep: A reads address 0 throughout, B writes addr 2 early on
    a_rd = 1; a_addr = 4'd0;
    b_wr = 1; b_addr = 4'd2; b_din = 16'hBEEF; b_be = 2'b11;
    rst_n = 1;
    wait_ready("ready_latency");
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      a_rd = 1; a_addr = 4'(i);
      cyc();
    end
    a_rd = 1; a_addr = 4'd2; cyc();
    if (CLEAR_BUILD) check("clr_drop_b_wr", a_dout, CLR);
    idle();

    // byte lanes
    a_wr = 1; a_addr = 4'd1; a_din = 16'h1234; a_be = 2'b11; cyc();
    a_din = 16'hFF00; a_be = 2'b10; cyc();
    a_wr = 0; a_rd = 1; cyc();
    check("byte_lanes", a_dout, 16'hFF34);
    idle();

    // same-address double write
    a_wr = 1; a_addr = 4'd3; a_din = 16'h1111; a_be = 2'b01;
    b_wr = 1; b_addr = 4'd3; b_din = 16'h2222; b_be = 2'b11;
    cyc();
    idle(); a_rd = 1; a_addr = 4'd3; cyc();
    check("collision", a_dout, 16'h2211);
    idle();

    // cross-port read during write
    a_wr = 1; a_addr = 4'd5; a_din = 16'h0007; a_be = 2'b11; cyc();
    a_din = 16'h0009; b_rd = 1; b_addr = 4'd5; cyc();
    check("rdw_old", b_dout, 16'h0007);
    a_wr = 0; cyc();
    check("rdw_new", b_dout, 16'h0009);
    idle();

    // RD+WR together holds DOUT; BE=0 write changes nothing
    a_rd = 1; a_addr = 4'd1; cyc();
    a_wr = 1; a_addr = 4'd3; a_din = 16'h5555; a_be = 2'b11; cyc();
    check("rdwr_hold", a_dout, 16'hFF34);
    a_wr = 0; cyc();
    check("rdwr_written", a_dout, 16'h5555);
    a_wr = 1; a_rd = 0; a_din = 16'h0000; a_be = 2'b00; cyc();
    a_wr = 0; a_rd = 1; cyc();
    check("be0_no_write", a_dout, 16'h5555);
    idle();

    // B writes, A reads back (edge addresses included)
    for (int i = 0; i < 3; i++) begin
      b_wr = 1; b_addr = vecs[i].ad; b_din = vecs[i].d; b_be = 2'b11; cyc();
      idle(); a_rd = 1; a_addr = vecs[i].ad; cyc();
      check("b_wr_a_rd", a_dout, vecs[i].d);
      idle();
    end

    // reset with nonzero DOUTs, then reset again mid-clear at address 9
    rst_n = 0; cyc();
    check("rst2_a_dout", a_dout, 16'h0000);
    check("rst2_b_dout", b_dout, 16'h0000);
    rst_n = 1;
    repeat (9) cyc();
    rst_n = 0; cyc();
    check("rst3_a_dout", a_dout, 16'h0000);
    check("rst3_b_dout", b_dout, 16'h0000);
    check("rst3_ready", {15'd0, ready}, 16'h0000);
    rst_n = 1;
    wait_ready("ready_after_midclear");
    idle();
    a_rd = 1; a_addr = 4'd9; cyc();
    if (CLEAR_BUILD) check("reclear_addr9", a_dout, CLR);
    idle();
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
